// File: rtl/bgpu_pkg.sv
// Shared types for the BGPU instruction-fetch blocks.
package bgpu_pkg;

    typedef enum logic [1:0] {
        IcLookup,
        IcMissReq,
        IcMissWait
    } ic_state_e;

endpackage

// File: rtl/ic_victim_sel.sv
// Per-set victim selection: lowest-index invalid way first, otherwise a round-robin pointer
// that advances only when it was actually used to pick the victim.
module ic_victim_sel #(
    parameter int unsigned NumWays = 2,
    localparam int unsigned WayBits = (NumWays > 1) ? $clog2(NumWays) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumWays-1:0] valid_i,
    input  logic               advance_i,
    output logic [WayBits-1:0] victim_o
);

    logic [WayBits-1:0] rr_q;

    // Descending scan so the lowest invalid way wins.
    always_comb begin
        victim_o = rr_q;
        for (int w = int'(NumWays) - 1; w >= 0; w--) begin
            if (!valid_i[w]) victim_o = WayBits'(w);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (advance_i && (&valid_i)) begin
            rr_q <= (rr_q == WayBits'(NumWays - 1)) ? '0 : rr_q + 1'b1;
        end
    end

endmodule

// File: rtl/assoc_instruction_cache.sv
// Set-associative blocking instruction cache with one outstanding line miss.
// Define BGPU_IC_PERF_COUNTERS_EN to add saturating hit/miss counters.
module assoc_instruction_cache
    import bgpu_pkg::*;
#(
    parameter int unsigned PcWidth          = 9,
    parameter int unsigned NumWarps         = 16,
    parameter int unsigned WarpWidth        = 4,
    parameter int unsigned EncInstWidth     = 32,
    parameter int unsigned CachelineIdxBits = 2,
    parameter int unsigned NumSets          = 4,
    parameter int unsigned NumWays          = 2,
    localparam int unsigned WarpIdBits    = $clog2(NumWarps),
    localparam int unsigned SubwarpIdBits = $clog2(WarpWidth),
    localparam int unsigned LineAddrBits  = PcWidth - CachelineIdxBits,
    localparam int unsigned LineBits      = EncInstWidth * (2 ** CachelineIdxBits)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     fe_valid_i,
    output logic                     ic_ready_o,
    input  logic [PcWidth-1:0]       fe_pc_i,
    input  logic [WarpWidth-1:0]     fe_act_mask_i,
    input  logic [WarpIdBits-1:0]    fe_warp_id_i,
    input  logic [SubwarpIdBits-1:0] fe_subwarp_id_i,
    output logic                     ic_valid_o,
    input  logic                     dec_ready_i,
    output logic [PcWidth-1:0]       ic_pc_o,
    output logic [WarpWidth-1:0]     ic_act_mask_o,
    output logic [WarpIdBits-1:0]    ic_warp_id_o,
    output logic [SubwarpIdBits-1:0] ic_subwarp_id_o,
    output logic [EncInstWidth-1:0]  ic_inst_o,
    output logic                     mem_req_o,
    input  logic                     mem_ready_i,
    output logic [LineAddrBits-1:0]  mem_addr_o,
    input  logic                     mem_valid_i,
    input  logic [LineBits-1:0]      mem_data_i
`ifdef BGPU_IC_PERF_COUNTERS_EN
    ,
    output logic [31:0]              hit_count_o,
    output logic [31:0]              miss_count_o
`endif
);

    localparam int unsigned SetBits  = $clog2(NumSets);
    localparam int unsigned TagBits  = LineAddrBits - SetBits;
    localparam int unsigned WayBits  = (NumWays > 1) ? $clog2(NumWays) : 1;
    localparam int unsigned NumWords = 2 ** CachelineIdxBits;

    typedef logic [TagBits-1:0]  tag_t;
    typedef logic [LineBits-1:0] line_t;
    typedef struct packed {
        logic [PcWidth-1:0]       pc;
        logic [WarpWidth-1:0]     act_mask;
        logic [WarpIdBits-1:0]    warp_id;
        logic [SubwarpIdBits-1:0] subwarp_id;
    } req_t;

    function automatic logic [EncInstWidth-1:0] word_sel(line_t line,
                                                         logic [CachelineIdxBits-1:0] w);
        logic [EncInstWidth-1:0] res;
        res = '0;
        for (int i = 0; i < int'(NumWords); i++) begin
            if (w == CachelineIdxBits'(i)) res = line[i*EncInstWidth +: EncInstWidth];
        end
        return res;
    endfunction

    ic_state_e               state_q;
    req_t                    req_q, out_req_q;
    logic                    stale_q, mem_req_q, out_valid_q;
    logic [EncInstWidth-1:0] out_inst_q;

    logic [NumWays-1:0] valid_q [NumSets];
    tag_t               tag_q   [NumSets][NumWays];
    line_t              data_q  [NumSets][NumWays];
    logic [WayBits-1:0] victim  [NumSets];

    req_t               fe_req;
    logic [SetBits-1:0] fe_set, req_set;
    tag_t               fe_tag;
    logic               hit, accept, install;
    line_t              hit_line;

    assign fe_req  = '{pc: fe_pc_i, act_mask: fe_act_mask_i, warp_id: fe_warp_id_i,
                       subwarp_id: fe_subwarp_id_i};
    assign fe_set  = fe_pc_i[CachelineIdxBits +: SetBits];
    assign fe_tag  = fe_pc_i[PcWidth-1 -: TagBits];
    assign req_set = req_q.pc[CachelineIdxBits +: SetBits];

    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        for (int w = 0; w < int'(NumWays); w++) begin
            if (valid_q[fe_set][w] && tag_q[fe_set][w] == fe_tag) begin
                hit      = 1'b1;
                hit_line = data_q[fe_set][w];
            end
        end
    end

    assign ic_ready_o = (state_q == IcLookup) && !flush_i && (!out_valid_q || dec_ready_i);
    assign accept     = fe_valid_i && ic_ready_o;
    // A flush, either earlier in this miss or on the fill cycle itself, blocks the install.
    assign install    = (state_q == IcMissWait) && mem_valid_i && !stale_q && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IcLookup;
            req_q       <= '0;
            stale_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_req_q   <= '0;
            out_inst_q  <= '0;
        end else begin
            if (out_valid_q && dec_ready_i) out_valid_q <= 1'b0;
            unique case (state_q)
                IcLookup: begin
                    if (accept && hit) begin
                        out_valid_q <= 1'b1;
                        out_req_q   <= fe_req;
                        out_inst_q  <= word_sel(hit_line, fe_pc_i[CachelineIdxBits-1:0]);
                    end else if (accept) begin
                        req_q     <= fe_req;
                        mem_req_q <= 1'b1;
                        state_q   <= IcMissReq;
                    end
                end
                IcMissReq: begin
                    if (flush_i) stale_q <= 1'b1;
                    if (mem_ready_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IcMissWait;
                    end
                end
                IcMissWait: begin
                    if (flush_i) stale_q <= 1'b1;
                    if (mem_valid_i) begin
                        out_valid_q <= 1'b1;
                        out_req_q   <= req_q;
                        out_inst_q  <= word_sel(mem_data_i, req_q.pc[CachelineIdxBits-1:0]);
                        stale_q     <= 1'b0;
                        state_q     <= IcLookup;
                    end
                end
                default: state_q <= IcLookup;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < int'(NumSets); s++) valid_q[s] <= '0;
        end else if (flush_i) begin
            for (int s = 0; s < int'(NumSets); s++) valid_q[s] <= '0;
        end else if (install) begin
            valid_q[req_set][victim[req_set]] <= 1'b1;
        end
    end

    // Tag and data arrays are qualified by valid_q and need no reset.
    always_ff @(posedge clk_i) begin
        if (install) begin
            tag_q[req_set][victim[req_set]]  <= req_q.pc[PcWidth-1 -: TagBits];
            data_q[req_set][victim[req_set]] <= mem_data_i;
        end
    end

    for (genvar s = 0; s < NumSets; s++) begin : g_victim
        ic_victim_sel #(
            .NumWays(NumWays)
        ) u_victim_sel (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .valid_i  (valid_q[s]),
            .advance_i(install && (req_set == SetBits'(s))),
            .victim_o (victim[s])
        );
    end

    assign ic_valid_o      = out_valid_q;
    assign ic_pc_o         = out_req_q.pc;
    assign ic_act_mask_o   = out_req_q.act_mask;
    assign ic_warp_id_o    = out_req_q.warp_id;
    assign ic_subwarp_id_o = out_req_q.subwarp_id;
    assign ic_inst_o       = out_inst_q;
    assign mem_req_o       = mem_req_q;
    assign mem_addr_o      = req_q.pc[PcWidth-1:CachelineIdxBits];

`ifdef BGPU_IC_PERF_COUNTERS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (accept) begin
            if (hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (!hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_assoc_instruction_cache.sv
// Randomised scoreboard bench for assoc_instruction_cache with directed corner scenarios.
module tb_assoc_instruction_cache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush_i = 1'b0;
    logic         fe_valid_i = 1'b0;
    logic         ic_ready_o;
    logic [8:0]   fe_pc_i = '0;
    logic [3:0]   fe_act_mask_i = '0;
    logic [3:0]   fe_warp_id_i = '0;
    logic [1:0]   fe_subwarp_id_i = '0;
    logic         ic_valid_o;
    logic         dec_ready_i = 1'b1;
    logic [8:0]   ic_pc_o;
    logic [3:0]   ic_act_mask_o;
    logic [3:0]   ic_warp_id_o;
    logic [1:0]   ic_subwarp_id_o;
    logic [31:0]  ic_inst_o;
    logic         mem_req_o;
    logic         mem_ready_i = 1'b0;
    logic [6:0]   mem_addr_o;
    logic         mem_valid_i = 1'b0;
    logic [127:0] mem_data_i = '0;
`ifdef BGPU_IC_PERF_COUNTERS_EN
    logic [31:0]  hit_count_o, miss_count_o;
`endif

    assoc_instruction_cache dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush_i),
        .fe_valid_i     (fe_valid_i),
        .ic_ready_o     (ic_ready_o),
        .fe_pc_i        (fe_pc_i),
        .fe_act_mask_i  (fe_act_mask_i),
        .fe_warp_id_i   (fe_warp_id_i),
        .fe_subwarp_id_i(fe_subwarp_id_i),
        .ic_valid_o     (ic_valid_o),
        .dec_ready_i    (dec_ready_i),
        .ic_pc_o        (ic_pc_o),
        .ic_act_mask_o  (ic_act_mask_o),
        .ic_warp_id_o   (ic_warp_id_o),
        .ic_subwarp_id_o(ic_subwarp_id_o),
        .ic_inst_o      (ic_inst_o),
        .mem_req_o      (mem_req_o),
        .mem_ready_i    (mem_ready_i),
        .mem_addr_o     (mem_addr_o),
        .mem_valid_i    (mem_valid_i),
        .mem_data_i     (mem_data_i)
`ifdef BGPU_IC_PERF_COUNTERS_EN
        ,
        .hit_count_o    (hit_count_o),
        .miss_count_o   (miss_count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  pc;
        logic [3:0]  mask;
        logic [3:0]  warp;
        logic [1:0]  sub;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          handshakes = 0;
    bit          rand_ready = 1'b0;
    logic [31:0] mem [512];

    // Reference cache: each set holds up to two line addresses plus a round-robin slot.
    int unsigned m_line [4][2];
    bit          m_val  [4][2];
    int unsigned m_rr   [4];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic bit m_lookup(int unsigned pc);
        int unsigned line = pc / 4;
        for (int w = 0; w < 2; w++) if (m_val[line % 4][w] && m_line[line % 4][w] == line) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_install(int unsigned line);
        int unsigned s = line % 4;
        int way = -1;
        for (int w = 0; w < 2; w++) if (!m_val[s][w] && way < 0) way = w;
        if (way < 0) begin
            way = int'(m_rr[s]);
            m_rr[s] = (m_rr[s] + 1) % 2;
        end
        m_val[s][way]  = 1'b1;
        m_line[s][way] = line;
    endfunction

    function automatic void m_flush();
        for (int s = 0; s < 4; s++) for (int w = 0; w < 2; w++) m_val[s][w] = 1'b0;
    endfunction

    function automatic void m_reset();
        m_flush();
        for (int s = 0; s < 4; s++) m_rr[s] = 0;
    endfunction

    function automatic logic [127:0] line_data(int unsigned line);
        logic [127:0] d;
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = mem[line*4 + k];
        return d;
    endfunction

    // Monitor: every decoder handshake pops and checks the oldest expected response.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && ic_valid_o && dec_ready_i) begin
            handshakes++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got pc 0x%0h with no response expected", ic_pc_o);
            end else begin
                e = sb_q.pop_front();
                chk("resp_pc", ic_pc_o, e.pc);
                chk("resp_mask", ic_act_mask_o, e.mask);
                chk("resp_warp", ic_warp_id_o, e.warp);
                chk("resp_subwarp", ic_subwarp_id_o, e.sub);
                chk("resp_inst", ic_inst_o, e.inst);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) dec_ready_i = ($urandom_range(0, 3) != 0);
    end

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses outstanding expected 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // flush_mode: 0 none, 1 flush while waiting for the fill, 2 flush on the fill cycle.
    // abandon: reset the DUT in MISS_WAIT and deliver the fill late.
    task automatic fetch(input int unsigned pc, input int flush_mode, input bit abandon);
        bit          got = 1'b0;
        bit          exp_hit;
        exp_t        e;
        int unsigned line = pc / 4;
        fe_pc_i         = pc[8:0];
        fe_act_mask_i   = 4'($urandom);
        fe_warp_id_i    = 4'($urandom);
        fe_subwarp_id_i = 2'($urandom);
        fe_valid_i      = 1'b1;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            got = ic_ready_o;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no ic_ready_o expected accept of pc 0x%0h", pc);
            fe_valid_i = 1'b0;
            return;
        end
        exp_hit = m_lookup(pc);
        e = '{pc: fe_pc_i, mask: fe_act_mask_i, warp: fe_warp_id_i, sub: fe_subwarp_id_i,
              inst: mem[pc]};
        @(posedge clk);
        #1;
        fe_valid_i = 1'b0;
        if (!abandon) sb_q.push_back(e);
        @(negedge clk);
        chk("mem_req_after_accept", mem_req_o, !exp_hit);
        if (exp_hit) begin
            chk("hit_latency", ic_valid_o, 1'b1);
        end else if (mem_req_o) begin
            chk("miss_addr", mem_addr_o, line);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("mem_req_hold", mem_req_o, 1'b1);
                chk("mem_addr_hold", mem_addr_o, line);
            end
            mem_ready_i = 1'b1;
            @(posedge clk);
            #1;
            mem_ready_i = 1'b0;
            if (abandon) begin
                rst_n = 1'b0;
                m_reset();
                #1;
                chk("reset_mem_req", mem_req_o, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                mem_valid_i = 1'b1;
                mem_data_i  = line_data(line);
                @(posedge clk);
                #1;
                mem_valid_i = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("no_resp_after_reset", ic_valid_o, 1'b0);
                end
            end else begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                if (flush_mode == 1) begin
                    flush_i = 1'b1;
                    @(posedge clk);
                    #1;
                    flush_i = 1'b0;
                end
                mem_valid_i = 1'b1;
                mem_data_i  = line_data(line);
                if (flush_mode == 2) flush_i = 1'b1;
                @(posedge clk);
                #1;
                mem_valid_i = 1'b0;
                flush_i     = 1'b0;
                mem_data_i  = {$urandom, $urandom, $urandom, $urandom};
                if (flush_mode != 0) m_flush();
                else m_install(line);
            end
        end else begin
            m_install(line);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        int hs0;
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_ic_valid", ic_valid_o, 1'b0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_ic_inst", ic_inst_o, 0);
        chk("rst_ic_pc", ic_pc_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ic_ready", ic_ready_o, 1'b1);
        @(posedge clk);
        #1;

        // Cold miss then a hit in the same line.
        fetch(32'h10, 0, 1'b0);
        fetch(32'h11, 0, 1'b0);
        wait_drain();
`ifdef BGPU_IC_PERF_COUNTERS_EN
        chk("hit_count", hit_count_o, 1);
        chk("miss_count", miss_count_o, 1);
`endif

        // Set-0 conflicts with round-robin eviction.
        do_reset();
        fetch(32'h00, 0, 1'b0);
        fetch(32'h10, 0, 1'b0);
        fetch(32'h20, 0, 1'b0);
        fetch(32'h00, 0, 1'b0);
        fetch(32'h10, 0, 1'b0);
        wait_drain();

        // Backpressure on a hit.
        fetch(32'h04, 0, 1'b0);
        wait_drain();
        dec_ready_i = 1'b0;
        hs0 = handshakes;
        fetch(32'h05, 0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", ic_valid_o, 1'b1);
            chk("bp_inst", ic_inst_o, mem[5]);
            chk("bp_pc", ic_pc_o, 9'h005);
            chk("bp_ready", ic_ready_o, 1'b0);
        end
        @(posedge clk);
        #1;
        dec_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_one_handshake", handshakes - hs0, 1);
        @(posedge clk);
        #1;

        // Flush while waiting for the fill: delivered but not installed.
        fetch(32'h30, 1, 1'b0);
        fetch(32'h30, 0, 1'b0);
        wait_drain();

        // Reset in MISS_WAIT abandons the miss.
        fetch(32'h50, 0, 1'b1);
        fetch(32'h50, 0, 1'b0);
        wait_drain();

        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int unsigned r = $urandom_range(0, 15);
            if (r == 0) begin
                flush_i = 1'b1;
                @(posedge clk);
                #1;
                flush_i = 1'b0;
                m_flush();
            end else if (r == 1) begin
                mem_valid_i = 1'b1;
                mem_data_i  = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk);
                #1;
                mem_valid_i = 1'b0;
            end else begin
                int fm = 0;
                if (r == 2) fm = 1;
                if (r == 3) fm = 2;
                fetch($urandom_range(0, 127), fm, 1'b0);
            end
        end
        rand_ready = 1'b0;
        dec_ready_i = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/assoc_instruction_cache.md
ASSOC_INSTRUCTION_CACHE -- requirements
Module: assoc_instruction_cache

Interface
REQ-001 SHALL have parameters: PcWidth (9, PC width in instructions); NumWarps (16); WarpWidth (4, threads/warp); EncInstWidth (32); CachelineIdxBits (2, log2 insts/line); NumSets (4, power of 2); NumWays (2, >=1).
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk_i in 1, rising-edge clock; rst_ni in 1, async reset, active low.
REQ-003 SHALL have ports: flush_i in 1, invalidate all lines.
REQ-004 SHALL have ports: fe_valid_i in 1; ic_ready_o out 1; fe_pc_i in PcWidth; fe_act_mask_i in WarpWidth; fe_warp_id_i in clog2(NumWarps); fe_subwarp_id_i in clog2(WarpWidth).
REQ-005 SHALL have ports: ic_valid_o out 1; dec_ready_i in 1; ic_pc_o, ic_act_mask_o, ic_warp_id_o, ic_subwarp_id_o, ic_inst_o out, same widths as the fetch side and EncInstWidth.
REQ-006 SHALL have ports: mem_req_o out 1; mem_ready_i in 1; mem_addr_o out PcWidth-CachelineIdxBits, line address; mem_valid_i in 1; mem_data_i in EncInstWidth*2^CachelineIdxBits, one full line with no ready.

Function
REQ-007 Line address = pc[PcWidth-1:CachelineIdxBits]; set = low log2(NumSets) bits of the line address; tag = the remaining upper bits; word = pc[CachelineIdxBits-1:0].
REQ-008 FSM states SHALL be LOOKUP, MISS_REQ and MISS_WAIT.
REQ-009 ic_ready_o = (state==LOOKUP) && !flush_i && (!ic_valid_o || dec_ready_i).
REQ-010 On accept with a valid way whose tag matches (hit), the output register SHALL load the request fields and the word, and ic_valid_o SHALL assert on the next cycle (hit latency 1).
REQ-011 On accept with a miss, the request SHALL be latched and the FSM SHALL go to MISS_REQ; mem_req_o SHALL stay high with mem_addr_o stable until mem_ready_i, then the FSM SHALL go to MISS_WAIT.
REQ-012 In MISS_WAIT, on mem_valid_i: install the line in the victim way, load the output register with the latched request and the requested word, assert ic_valid_o next cycle, and return to LOOKUP.
REQ-013 Victim SHALL be the lowest-index invalid way; if all ways are valid, the victim SHALL be the set's round-robin pointer, which then advances modulo NumWays.
REQ-014 The output register SHALL hold all ic_* outputs stable while ic_valid_o && !dec_ready_i.
REQ-015 flush_i SHALL clear all valid bits at the next edge; round-robin pointers SHALL be unchanged.
REQ-016 A flush asserted in MISS_REQ or MISS_WAIT SHALL set a stale flag; the pending fill SHALL still be delivered to the decoder but SHALL NOT be installed.
REQ-017 If flush_i and a fill occur in the same cycle, the fill SHALL NOT be installed.
REQ-018 At most one miss SHALL be outstanding; mem_valid_i outside MISS_WAIT SHALL be ignored.
REQ-019 Responses SHALL be returned in accept order.

Reset
REQ-020 The reset state SHALL be: state LOOKUP; all valid bits, round-robin pointers and the stale flag 0; ic_valid_o=0, mem_req_o=0, all data outputs 0; ic_ready_o=1 after reset release.
REQ-021 A reset during MISS_REQ or MISS_WAIT SHALL abandon the miss; a later mem_valid_i SHALL be ignored.

Configuration
REQ-022 With BGPU_IC_PERF_COUNTERS_EN defined, the block SHALL add outputs hit_count_o and miss_count_o (32 bits each, saturating, reset 0), each incremented at the accept of a hit or miss respectively.
REQ-023 Without BGPU_IC_PERF_COUNTERS_EN, these ports and counters SHALL be absent.

Structure
REQ-024 bgpu_pkg SHALL hold the FSM state enum ic_state_e.
REQ-025 Line, tag and request structs SHALL be derived locally from the parameters.
REQ-026 The round-robin and invalid-first victim logic per set SHALL be a sub-module ic_victim_sel, parameterised by NumWays.

Verification (PcWidth=9, CachelineIdxBits=2, NumSets=4, NumWays=2, memory inst[i] preloaded)
REQ-027 Cold miss then hit: fetch pc 0x10 -> mem_addr_o=0x4; fill -> ic_inst_o=inst[0x10]. Fetch pc 0x11 -> ic_valid_o one cycle after accept, no mem_req_o.
REQ-028 Conflict: fetch pc 0x00, 0x10, 0x20 (all set 0) -> 3 misses, and 0x20 evicts line 0x0. A refetch of pc 0x00 misses; a refetch of pc 0x10 misses (evicted by the 0x00 refill).
REQ-029 Backpressure: dec_ready_i low for 5 cycles after a hit -> outputs stable, ic_ready_o=0, exactly one handshake.
REQ-030 Flush in MISS_WAIT for pc 0x30 -> decoder still receives inst[0x30]; a refetch of pc 0x30 issues mem_addr_o=0xC again.
REQ-031 Reset in MISS_WAIT, then a late mem_valid_i -> no ic_valid_o; the next fetch of the same pc misses.
REQ-032 With BGPU_IC_PERF_COUNTERS_EN, REQ-027 -> hit_count_o=1, miss_count_o=1.
